// File: rtl/apb_pkg.sv
// Shared definitions for the multi-slave APB master: FSM state encoding and
// the response error codes returned on rsp_err.
package apb_pkg;

   // Master FSM states
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   // Response error codes
   localparam logic [1:0] APB_OKAY    = 2'b00;
   localparam logic [1:0] APB_SLVERR  = 2'b01;
   localparam logic [1:0] APB_DECERR  = 2'b10;
   localparam logic [1:0] APB_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_slv_mux.sv
// Return-path multiplexer: picks the read data, ready and error of the
// currently selected slave. A select value with no matching slave yields
// all-zero outputs so an out-of-range index can never look like a response.
module apb_slv_mux #(
   parameter int NSLV   = 4,
   parameter int DATA_W = 32,
   parameter int SELW   = 2
) (
   input  logic [SELW-1:0]        i_sel,
   input  logic [NSLV*DATA_W-1:0] i_prdata,
   input  logic [NSLV-1:0]        i_pready,
   input  logic [NSLV-1:0]        i_pslverr,
   output logic [DATA_W-1:0]      o_rdata,
   output logic                   o_ready,
   output logic                   o_slverr
);

   // Select the matching slave's signals; everything else is ignored
   always_comb begin
      o_rdata  = '0;
      o_ready  = 1'b0;
      o_slverr = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (i_sel == SELW'(i)) begin
            o_rdata  = i_prdata[i*DATA_W +: DATA_W];
            o_ready  = i_pready[i];
            o_slverr = i_pslverr[i];
         end
      end
   end

endmodule

// File: rtl/apb_master_mux.sv
// APB3 master with address-decoded slave selection. Accepts one command at a
// time, runs a SETUP/ACCESS transfer on the selected slave, and returns data
// plus an error code (OKAY, SLVERR, DECERR, TIMEOUT) on the response channel.
module apb_master_mux
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 4,
   parameter int SLV_LSB = 12,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [ADDR_W-1:0]      cmd_addr,
   input  logic [DATA_W-1:0]      cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic [1:0]             rsp_err,
   output logic [NSLV-1:0]        psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [ADDR_W-1:0]      paddr,
   output logic [DATA_W-1:0]      pwdata,
   input  logic [NSLV*DATA_W-1:0] prdata,
   input  logic [NSLV-1:0]        pready,
   input  logic [NSLV-1:0]        pslverr
);

   localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]        r_state;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [SELW-1:0]   r_sel;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_err;
   logic [CNTW-1:0]   r_cnt;

   logic [SELW-1:0]   w_cmdSel;
   logic              w_decErr;
   logic              w_timeoutHit;
   logic [DATA_W-1:0] w_selRdata;
   logic              w_selReady;
   logic              w_selSlverr;

   assign w_cmdSel     = cmd_addr[SLV_LSB +: SELW];
   assign w_decErr     = 32'(w_cmdSel) >= 32'(NSLV);
   assign w_timeoutHit = (TIMEOUT != 0) && (r_cnt == CNTW'(TIMEOUT - 1));

   apb_slv_mux #(
      .NSLV   (NSLV),
      .DATA_W (DATA_W),
      .SELW   (SELW)
   ) u_slvMux (
      .i_sel     (r_sel),
      .i_prdata  (prdata),
      .i_pready  (pready),
      .i_pslverr (pslverr),
      .o_rdata   (w_selRdata),
      .o_ready   (w_selReady),
      .o_slverr  (w_selSlverr)
   );

   // Transfer FSM with command capture, wait-state timeout and response hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_sel   <= '0;
         r_rdata <= '0;
         r_err   <= APB_OKAY;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_write <= cmd_write;
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_sel   <= w_cmdSel;
                  r_rdata <= '0;
                  if (w_decErr) begin
                     r_err   <= APB_DECERR;
                     r_state <= RESP;
                  end else begin
                     r_err   <= APB_OKAY;
                     r_state <= SETUP;
                  end
               end
            end
            SETUP: begin
               r_cnt   <= '0;
               r_state <= ACCESS;
            end
            ACCESS: begin
               if (w_selReady) begin
                  if (w_selSlverr) begin
                     r_err   <= APB_SLVERR;
                     r_rdata <= '0;
                  end else begin
                     r_err   <= APB_OKAY;
                     r_rdata <= r_write ? '0 : w_selRdata;
                  end
                  r_state <= RESP;
               end else if (w_timeoutHit) begin
                  r_err   <= APB_TIMEOUT;
                  r_rdata <= '0;
                  r_state <= RESP;
               end else if (TIMEOUT != 0) begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (r_state == IDLE) && !rst;
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign psel      = ((r_state == SETUP) || (r_state == ACCESS)) ? (NSLV'(1) << r_sel) : '0;
   assign penable   = (r_state == ACCESS);
   assign pwrite    = r_write;
   assign paddr     = r_addr;
   assign pwdata    = r_wdata;

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
Parametrised APB3 master. It is the successor to the single-slave apb_master.
- Accepts read/write commands on a valid/ready interface and decodes the target slave from address bits.
- Drives a shared APB bus with one PSEL per slave.
- Honours PREADY wait states, captures PSLVERR, and aborts hung transfers with a timeout.
- Returns read data and an error code on a valid/ready response channel. One transfer is outstanding at a time.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width (8, 16 or 32).
- NSLV, 4: number of APB slaves (1..16).
- SLV_LSB, 12: LSB of the slave-select field in cmd_addr. Field width is SELW = max(1, clog2(NSLV)).
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: command valid.
- cmd_ready, out, 1: command accepted when cmd_valid & cmd_ready.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_W: transfer address.
- cmd_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: response consumed when rsp_valid & rsp_ready.
- rsp_rdata, out, DATA_W: read data. 0 for writes and for errors.
- rsp_err, out, 2: 00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT.
- psel, out, NSLV: one-hot slave select.
- penable, out, 1: APB enable.
- pwrite, out, 1: APB direction.
- paddr, out, ADDR_W: APB address.
- pwdata, out, DATA_W: APB write data.
- prdata, in, NSLV*DATA_W: per-slave read data; slave i occupies [i*DATA_W +: DATA_W].
- pready, in, NSLV: per-slave ready.
- pslverr, in, NSLV: per-slave error.

Behaviour:
- Reset values: cmd_ready=0 during rst, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=00, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0. State = IDLE. Timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, register write, addr, wdata and sel = cmd_addr[SLV_LSB +: SELW].
  - sel >= NSLV: go to RESP with DECERR; no APB activity.
  - Otherwise go to SETUP.
- SETUP (one cycle): psel[sel]=1, penable=0, paddr/pwrite/pwdata driven from the registers. Next state ACCESS.
- ACCESS:
  - psel[sel]=1, penable=1; address, direction and data held stable.
  - pready[sel]=1: capture rdata (reads only), set err = pslverr[sel] ? SLVERR : OKAY, go to RESP.
  - On SLVERR, rdata=0.
  - Else, if TIMEOUT≠0 and the counter reaches TIMEOUT-1: set TIMEOUT error and go to RESP. psel and penable drop in the next cycle.
  - Counter clears when entering ACCESS.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - rsp_rdata and rsp_err held stable until rsp_ready.
  - On handshake go to IDLE. cmd_ready stays 0 until IDLE, so there is no back-to-back overlap.
- Minimum latency: command accepted at cycle 0, SETUP at 1, ACCESS at 2 with pready=1, rsp_valid at 3. Peak throughput is one transfer per 4 cycles when rsp_ready is held high.
- Only psel[sel] is ever asserted. pready and pslverr from unselected slaves are ignored.
- paddr and pwdata keep their last values when idle; there is no toggling.
- rst asserted mid-transfer: all outputs return to reset values on the next edge, and the pending command and response are dropped.
- NSLV=1: SELW=1, and decode address bit value 1 gives DECERR.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3;
  - error codes: APB_OKAY, APB_SLVERR, APB_DECERR, APB_TIMEOUT.
- Natural sub-module apb_slv_mux: combinational selection of prdata, pready and pslverr by sel.
- The FSM, timeout counter and command/response registers stay in apb_master_mux.

Test Plan:
- Write addr 0x0000_1004, data 0xDEAD_BEEF; slave 1 pready=1 immediately → psel=4'b0010 in SETUP then ACCESS, pwdata=0xDEAD_BEEF; rsp_valid at cycle 3 with rsp_err=00.
- Read addr 0x0000_2008; slave 2 holds pready=0 for 3 ACCESS cycles, prdata=0x1234_5678 → rsp_rdata=0x1234_5678, rsp_err=00, rsp_valid at cycle 6.
- Read from slave 3 with pready=1 and pslverr=1 → rsp_err=01, rsp_rdata=0.
- NSLV=3, addr 0x0000_3000 → rsp_err=10 one cycle after accept; psel never asserted.
- TIMEOUT=16, slave 0 pready stuck at 0 → after 16 ACCESS cycles rsp_err=11, psel and penable deasserted; the next command completes normally.
- rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err stable and cmd_ready=0. Then assert rst during a later ACCESS → next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=0 until rst drops.
